// File: rtl/traffic_pkg.sv
// -----------------------------------------------------------------------------
// traffic_pkg
// Shared phase codes for the light_signals bus. The Lights lamp decoder and
// traffic_sequencer both import this package so the one-hot codes can only be
// defined in one place.
// -----------------------------------------------------------------------------
package traffic_pkg;

    localparam int CODE_W = 7;

    localparam logic [CODE_W-1:0] CODE_MG   = 7'b100_0000;
    localparam logic [CODE_W-1:0] CODE_MY   = 7'b010_0000;
    localparam logic [CODE_W-1:0] CODE_AR1  = 7'b001_0000;
    localparam logic [CODE_W-1:0] CODE_SG   = 7'b000_1000;
    localparam logic [CODE_W-1:0] CODE_SY   = 7'b000_0100;
    localparam logic [CODE_W-1:0] CODE_AR2  = 7'b000_0010;
    localparam logic [CODE_W-1:0] CODE_WALK = 7'b000_0001;

    // The state encoding is the bus code itself, so the output register can be
    // loaded straight from the next-state value.
    typedef enum logic [CODE_W-1:0] {
        S_MG   = CODE_MG,
        S_MY   = CODE_MY,
        S_AR1  = CODE_AR1,
        S_SG   = CODE_SG,
        S_SY   = CODE_SY,
        S_AR2  = CODE_AR2,
        S_WALK = CODE_WALK
    } state_t;

    localparam logic [7:0] TCNT_MAX = 8'hFF;

endpackage

// File: rtl/traffic_sequencer_if.sv
// -----------------------------------------------------------------------------
// traffic_sequencer_if
// Groups the request inputs and the light/ack outputs of the sequencer.
//   side_sensor   : side-road vehicle present (asynchronous level)
//   walk_btn      : pedestrian button (asynchronous level)
//   light_signals : one-hot phase code driven to Lights
//   side_ack      : one-clock pulse on entry to side green
//   walk_ack      : one-clock pulse on entry to walk
// master = the sequencer (drives the lights), slave = sensors/lamp side.
// -----------------------------------------------------------------------------
interface traffic_sequencer_if;
    import traffic_pkg::*;

    logic              side_sensor;
    logic              walk_btn;
    logic [CODE_W-1:0] light_signals;
    logic              side_ack;
    logic              walk_ack;

    modport master (
        input  side_sensor,
        input  walk_btn,
        output light_signals,
        output side_ack,
        output walk_ack
    );

    modport slave (
        output side_sensor,
        output walk_btn,
        input  light_signals,
        input  side_ack,
        input  walk_ack
    );

endinterface

// File: rtl/tick_prescaler.sv
// -----------------------------------------------------------------------------
// tick_prescaler
// Divides clk down to a one-clock timing tick every TICK_DIV clocks.
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   tick : high for the one cycle in which the count equals TICK_DIV-1
// -----------------------------------------------------------------------------
module tick_prescaler #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [CW-1:0] cnt;

    assign tick = (cnt == CW'(TICK_DIV - 1));

    // NOTE: sequential state is written with non-blocking assignments so every
    // flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/traffic_sequencer.sv
// -----------------------------------------------------------------------------
// traffic_sequencer
// Timed main/side/pedestrian phase sequencer; sole driver of light_signals.
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : traffic_sequencer_if.master
//          in  side_sensor, walk_btn (asynchronous, synchronized here)
//          out light_signals (registered one-hot), side_ack, walk_ack
// -----------------------------------------------------------------------------
module traffic_sequencer
    import traffic_pkg::*;
#(
    parameter int TICK_DIV  = 50_000_000,
    parameter int MG_MIN    = 10,
    parameter int Y_TIME    = 3,
    parameter int AR_TIME   = 2,
    parameter int SG_TIME   = 8,
    parameter int WALK_TIME = 6
) (
    input  logic clk,
    input  logic rst,
    traffic_sequencer_if.master bus
);

    state_t     state;
    state_t     state_next;
    logic [7:0] tcnt;
    logic       tick;
    logic       side_s1, side_s2, side_pend;
    logic       walk_s1, walk_s2, walk_pend;
    logic       state_entry;
    logic       enter_sg;
    logic       enter_walk;

    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    // NOTE: every variable written here gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            S_MG:   if (tick && tcnt >= 8'(MG_MIN - 1) && (side_pend || walk_pend))
                        state_next = S_MY;
            S_MY:   if (tick && tcnt == 8'(Y_TIME - 1))
                        state_next = S_AR1;
            S_AR1:  if (tick && tcnt == 8'(AR_TIME - 1))
                        state_next = side_pend ? S_SG : S_WALK;
            S_SG:   if (tick && tcnt == 8'(SG_TIME - 1))
                        state_next = S_SY;
            S_SY:   if (tick && tcnt == 8'(Y_TIME - 1))
                        state_next = S_AR2;
            S_AR2:  if (tick && tcnt == 8'(AR_TIME - 1))
                        state_next = walk_pend ? S_WALK : S_MG;
            S_WALK: if (tick && tcnt == 8'(WALK_TIME - 1))
                        state_next = S_MG;
            // A corrupted (non-one-hot) register parks in all-red.
            default: state_next = S_AR2;
        endcase
    end

    // Any change of state, including recovery from an illegal code, is an
    // entry and restarts the phase timer.
    assign state_entry = (state_next != state);
    assign enter_sg    = state_entry && (state_next == S_SG);
    assign enter_walk  = state_entry && (state_next == S_WALK);

    // The output is loaded from the next-state value rather than mirrored from
    // the state flop, so it only ever carries a legal one-hot code.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state             <= S_AR2;
            bus.light_signals <= CODE_AR2;
        end else begin
            state             <= state_next;
            bus.light_signals <= state_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tcnt         <= '0;
            side_s1      <= 1'b0;
            side_s2      <= 1'b0;
            walk_s1      <= 1'b0;
            walk_s2      <= 1'b0;
            side_pend    <= 1'b0;
            walk_pend    <= 1'b0;
            bus.side_ack <= 1'b0;
            bus.walk_ack <= 1'b0;
        end else begin
            if (state_entry) begin
                tcnt <= '0;
            end else if (tick && tcnt != TCNT_MAX) begin
                tcnt <= tcnt + 8'd1;
            end

            side_s1 <= bus.side_sensor;
            side_s2 <= side_s1;
            walk_s1 <= bus.walk_btn;
            walk_s2 <= walk_s1;

            // Clear on entry beats a same-cycle set; requests are dropped
            // while their own phase is being served.
            if (enter_sg) begin
                side_pend <= 1'b0;
            end else if (side_s2 && state != S_SG) begin
                side_pend <= 1'b1;
            end

            if (enter_walk) begin
                walk_pend <= 1'b0;
            end else if (walk_s2 && state != S_WALK) begin
                walk_pend <= 1'b1;
            end

            bus.side_ack <= enter_sg;
            bus.walk_ack <= enter_walk;
        end
    end

endmodule

// File: tb/tb_traffic_sequencer.sv
// -----------------------------------------------------------------------------
// tb_traffic_sequencer
// Directed scenarios against traffic_sequencer with a phase scoreboard: each
// scenario queues the (code, clock edge) of every phase it expects; a monitor
// pops an entry each time light_signals changes and compares it.
// -----------------------------------------------------------------------------
module tb_traffic_sequencer;
    import traffic_pkg::*;

    typedef struct {
        logic [CODE_W-1:0] code;
        int                edge_n;
    } phase_t;

    logic clk;
    logic rst;
    int   cyc;
    int   n_cmp;
    int   n_err;
    int   side_acks;
    int   walk_acks;
    logic [CODE_W-1:0] prev_code;
    phase_t exp_q[$];

    traffic_sequencer_if bus ();

    traffic_sequencer #(
        .TICK_DIV  (4),
        .MG_MIN    (3),
        .Y_TIME    (2),
        .AR_TIME   (1),
        .SG_TIME   (4),
        .WALK_TIME (5)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Rising edges since reset release; at a falling edge cyc == n means the
    // outputs reflect edge n.
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h (cyc %0d)", tag, obs, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            prev_code = bus.light_signals;
        end else begin
            check("onehot", 32'($onehot(bus.light_signals)), 32'd1);
            if (bus.side_ack) begin
                side_acks++;
                check("side_ack_code", 32'(bus.light_signals), 32'(CODE_SG));
                check("side_ack_first", 32'(prev_code != CODE_SG), 32'd1);
            end
            if (bus.walk_ack) begin
                walk_acks++;
                check("walk_ack_code", 32'(bus.light_signals), 32'(CODE_WALK));
                check("walk_ack_first", 32'(prev_code != CODE_WALK), 32'd1);
            end
            if (bus.light_signals !== prev_code) begin
                if (exp_q.size() == 0) begin
                    check("phase_expected", 32'(exp_q.size()), 32'd1);
                end else begin
                    phase_t e;
                    e = exp_q.pop_front();
                    check("phase_code", 32'(bus.light_signals), 32'(e.code));
                    check("phase_edge", 32'(cyc), 32'(e.edge_n));
                end
                prev_code = bus.light_signals;
            end
        end
    end

    // Advance to the falling edge after rising edge n, then step clear of it.
    task automatic wait_cyc(input int n);
        do @(negedge clk); while (cyc < n);
        #1;
    endtask

    task automatic expect_phase(input logic [CODE_W-1:0] code, input int edge_n);
        phase_t e;
        e.code   = code;
        e.edge_n = edge_n;
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        rst             = 1'b1;
        bus.side_sensor = 1'b0;
        bus.walk_btn    = 1'b0;
        exp_q.delete();
        side_acks = 0;
        walk_acks = 0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_light", 32'(bus.light_signals), 32'(CODE_AR2));
        check("rst_side_ack", 32'(bus.side_ack), 32'd0);
        check("rst_walk_ack", 32'(bus.walk_ack), 32'd0);
        check("rst_tcnt", 32'(dut.tcnt), 32'd0);
        check("rst_side_pend", 32'(dut.side_pend), 32'd0);
        check("rst_walk_pend", 32'(dut.walk_pend), 32'd0);
        rst = 1'b0;
    endtask

    task automatic pulse_side_walk(input bit side, input bit walk, input int at_edge);
        wait_cyc(at_edge - 1);
        bus.side_sensor = side;
        bus.walk_btn    = walk;
        wait_cyc(at_edge);
        bus.side_sensor = 1'b0;
        bus.walk_btn    = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst   = 1'b1;
        bus.side_sensor = 1'b0;
        bus.walk_btn    = 1'b0;

        // No requests: all-red until edge 4, then main green holds.
        do_reset();
        expect_phase(CODE_MG, 4);
        wait_cyc(3);
        check("idle_ar2_before_tick", 32'(bus.light_signals), 32'(CODE_AR2));
        wait_cyc(204);
        check("idle_mg_hold", 32'(bus.light_signals), 32'(CODE_MG));
        check("idle_queue_drained", 32'(exp_q.size()), 32'd0);

        // Side request sampled at edge 20: pending after edge 22, served on the
        // tick at edge 24.
        do_reset();
        expect_phase(CODE_MG, 4);
        expect_phase(CODE_MY, 24);
        expect_phase(CODE_AR1, 32);
        expect_phase(CODE_SG, 36);
        expect_phase(CODE_SY, 52);
        expect_phase(CODE_AR2, 60);
        expect_phase(CODE_MG, 64);
        pulse_side_walk(1'b1, 1'b0, 20);
        wait_cyc(22);
        check("side_pend_latency", 32'(dut.side_pend), 32'd1);
        wait_cyc(120);
        check("side_queue_drained", 32'(exp_q.size()), 32'd0);
        check("side_ack_count", 32'(side_acks), 32'd1);
        check("side_walk_ack_count", 32'(walk_acks), 32'd0);
        check("side_pend_cleared", 32'(dut.side_pend), 32'd0);

        // Walk only: AR1 goes straight to WALK for 20 clocks.
        do_reset();
        expect_phase(CODE_MG, 4);
        expect_phase(CODE_MY, 24);
        expect_phase(CODE_AR1, 32);
        expect_phase(CODE_WALK, 36);
        expect_phase(CODE_MG, 56);
        pulse_side_walk(1'b0, 1'b1, 20);
        wait_cyc(120);
        check("walk_queue_drained", 32'(exp_q.size()), 32'd0);
        check("walk_ack_count", 32'(walk_acks), 32'd1);
        check("walk_side_ack_count", 32'(side_acks), 32'd0);

        // Both together: side first, then AR2 -> WALK -> MG.
        do_reset();
        expect_phase(CODE_MG, 4);
        expect_phase(CODE_MY, 24);
        expect_phase(CODE_AR1, 32);
        expect_phase(CODE_SG, 36);
        expect_phase(CODE_SY, 52);
        expect_phase(CODE_AR2, 60);
        expect_phase(CODE_WALK, 64);
        expect_phase(CODE_MG, 84);
        pulse_side_walk(1'b1, 1'b1, 20);
        wait_cyc(140);
        check("both_queue_drained", 32'(exp_q.size()), 32'd0);
        check("both_side_ack_count", 32'(side_acks), 32'd1);
        check("both_walk_ack_count", 32'(walk_acks), 32'd1);

        // Reset mid side-green with a walk request pending.
        do_reset();
        expect_phase(CODE_MG, 4);
        expect_phase(CODE_MY, 24);
        expect_phase(CODE_AR1, 32);
        expect_phase(CODE_SG, 36);
        pulse_side_walk(1'b1, 1'b0, 20);
        pulse_side_walk(1'b0, 1'b1, 38);
        wait_cyc(42);
        check("midsg_light", 32'(bus.light_signals), 32'(CODE_SG));
        check("midsg_walk_pend_set", 32'(dut.walk_pend), 32'd1);
        check("midsg_queue_drained", 32'(exp_q.size()), 32'd0);
        rst = 1'b1;
        #1;
        check("midsg_rst_light", 32'(bus.light_signals), 32'(CODE_AR2));
        check("midsg_rst_side_pend", 32'(dut.side_pend), 32'd0);
        check("midsg_rst_walk_pend", 32'(dut.walk_pend), 32'd0);
        check("midsg_rst_tcnt", 32'(dut.tcnt), 32'd0);
        @(negedge clk);
        #1;
        rst = 1'b0;
        expect_phase(CODE_MG, 4);
        wait_cyc(3);
        check("midsg_post_ar2", 32'(bus.light_signals), 32'(CODE_AR2));
        wait_cyc(4);
        check("midsg_post_mg", 32'(bus.light_signals), 32'(CODE_MG));
        wait_cyc(12);
        check("midsg_post_queue_drained", 32'(exp_q.size()), 32'd0);

        // Corrupt the state register: all-red on the next edge, then the tick
        // at edge 12 ends the one-tick all-red.
        do_reset();
        expect_phase(CODE_MG, 4);
        expect_phase(CODE_AR2, 11);
        expect_phase(CODE_MG, 12);
        wait_cyc(10);
        force dut.state = state_t'(7'b000_0011);
        #1;
        release dut.state;
        wait_cyc(11);
        check("illegal_recover_light", 32'(bus.light_signals), 32'(CODE_AR2));
        check("illegal_recover_tcnt", 32'(dut.tcnt), 32'd0);
        wait_cyc(20);
        check("illegal_queue_drained", 32'(exp_q.size()), 32'd0);
        check("illegal_light_final", 32'(bus.light_signals), 32'(CODE_MG));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
